// File: rtl/candy_pkg.sv
// Shared coin constants, FSM state encoding and coin decode helper for the candy vending controller.
// Purely declarative; no latency or backpressure of its own.
package candy_pkg;

  localparam int NICKEL_C  = 5;
  localparam int DIME_C    = 10;
  localparam int QUARTER_C = 25;

  localparam int VAL_W    = 5;
  localparam int N_STATES = 12;

  // One state per 5c credit step; S0 is idle. PRICE only reaches S(PRICE-5).
  typedef enum logic [3:0] {
    S0, S5, S10, S15, S20, S25, S30, S35, S40, S45, S50, S55
  } state_t;

  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic             invalid;
  } coin_t;

  function automatic coin_t coin_value(input logic n, input logic d, input logic q);
    coin_t r;
    r.value   = '0;
    r.invalid = 1'b0;
    case ({n, d, q})
      3'b000:  r.value = '0;
      3'b100:  r.value = VAL_W'(NICKEL_C);
      3'b010:  r.value = VAL_W'(DIME_C);
      3'b001:  r.value = VAL_W'(QUARTER_C);
      default: r.invalid = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/candy_coin_decode.sv
// Coin strobe decode: one-hot check and cents lookup, multi-strobe cycles report invalid with value 0.
// Combinational, zero latency; no backpressure (strobes are sampled every cycle).
module candy_coin_decode
  import candy_pkg::*;
(
  input  logic             n,
  input  logic             d,
  input  logic             q,
  output logic [VAL_W-1:0] value,
  output logic             invalid
);

  coin_t coin;

  assign coin    = coin_value(n, d, q);
  assign value   = coin.value;
  assign invalid = coin.invalid;

endmodule

// File: rtl/candy_vend_fsm.sv
// Candy vending controller: accumulates coin credit, pulses y with change at PRICE; CANDY_SALES_CNT_EN adds sales_cnt.
// All outputs registered, 1 cycle coin-to-vend latency; no backpressure, one coin accepted every cycle.
module candy_vend_fsm
  import candy_pkg::*;
#(
  parameter int PRICE = 15,
  parameter int CW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          n,
  input  logic          d,
  input  logic          q,
  output logic          y,
  output logic [CW-1:0] change,
  output logic          coin_err,
  output logic [CW-1:0] credit
`ifdef CANDY_SALES_CNT_EN
  ,
  output logic [15:0]   sales_cnt
`endif
);

  logic [VAL_W-1:0] coin_val;
  logic             coin_invalid;

  state_t           state_q, state_d;
  logic             vend_q, vend_d;
  logic [CW-1:0]    change_q, change_d;
  logic             err_q, err_d;
  logic [CW-1:0]    sum;

  candy_coin_decode u_decode (
    .n       (n),
    .d       (d),
    .q       (q),
    .value   (coin_val),
    .invalid (coin_invalid)
  );

  // Credit is implied by the state, so it is reset-clean without a separate register.
  assign credit = CW'(int'(state_q) * NICKEL_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S0;
      vend_q   <= 1'b0;
      change_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vend_q   <= vend_d;
      change_q <= change_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = S0;
    vend_d   = 1'b0;
    change_d = '0;
    err_d    = coin_invalid;
    sum      = credit + CW'(coin_val);
    if (sum >= CW'(PRICE)) begin
      // Vend and drop back to idle; overpayment leaves as change, nothing carries over.
      vend_d   = 1'b1;
      change_d = sum - CW'(PRICE);
    end else begin
      for (int i = 0; i < N_STATES; i++) begin
        if (sum == CW'(i * NICKEL_C)) state_d = state_t'(4'(i));
      end
    end
  end

  assign y        = vend_q;
  assign change   = change_q;
  assign coin_err = err_q;

`ifdef CANDY_SALES_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sales_cnt <= '0;
    else if (vend_d) sales_cnt <= sales_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_candy_vend_fsm.sv
// Bench for candy_vend_fsm: directed sequence plus random coins against an arithmetic credit model.
module tb_candy_vend_fsm;

  localparam int PRICE = 15;
  localparam int CW    = 7;

  logic          clk;
  logic          reset;
  logic          n, d, q;
  logic          y;
  logic [CW-1:0] change;
  logic          coin_err;
  logic [CW-1:0] credit;
`ifdef CANDY_SALES_CNT_EN
  logic [15:0]   sales_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  int m_credit = 0;
  int m_y      = 0;
  int m_change = 0;
  int m_err    = 0;

  candy_vend_fsm #(.PRICE(PRICE), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .n        (n),
    .d        (d),
    .q        (q),
    .y        (y),
    .change   (change),
    .coin_err (coin_err),
    .credit   (credit)
`ifdef CANDY_SALES_CNT_EN
    ,
    .sales_cnt(sales_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".credit"},   32'(credit),   32'(m_credit));
    chk({tag, ".y"},        32'(y),        32'(m_y));
    chk({tag, ".change"},   32'(change),   32'(m_change));
    chk({tag, ".coin_err"}, 32'(coin_err), 32'(m_err));
  endtask

  // Reference: coins add cents; a multi-coin cycle is ignored and flagged; reaching PRICE vends and empties.
  task automatic model_edge(input logic nn, input logic dd, input logic qq);
    int cnt, val, total;
    cnt = int'(nn) + int'(dd) + int'(qq);
    val = (cnt > 1) ? 0 : (nn ? 5 : 0) + (dd ? 10 : 0) + (qq ? 25 : 0);
    m_err = (cnt > 1) ? 1 : 0;
    total = m_credit + val;
    if (total >= PRICE) begin
      m_y = 1; m_change = total - PRICE; m_credit = 0;
    end else begin
      m_y = 0; m_change = 0; m_credit = total;
    end
  endtask

  task automatic step(input string tag, input logic nn, input logic dd, input logic qq);
    n = nn; d = dd; q = qq;
    @(posedge clk);
    #1;
    model_edge(nn, dd, qq);
    chk_all(tag);
  endtask

  initial begin
    logic [2:0] mask;
    reset = 1'b1;
    n = 1'b0; d = 1'b0; q = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    reset = 1'b0;

    step("nd_n", 1, 0, 0);
    step("nd_d", 0, 1, 0);
    step("dd_1", 0, 1, 0);
    step("dd_2", 0, 1, 0);
    step("nnnn_1", 1, 0, 0);
    step("nnnn_2", 1, 0, 0);
    step("nnnn_3", 1, 0, 0);
    step("nnnn_4", 1, 0, 0);
    step("idle_keep", 0, 0, 0);
    step("top_up", 0, 1, 0);
    step("q_from0", 0, 0, 1);
    step("d_to10", 0, 1, 0);
    step("q_from10", 0, 0, 1);
    step("n_to5", 1, 0, 0);
    step("nd_err", 1, 1, 0);
    step("err_clear", 0, 0, 0);
    step("all3_err", 1, 1, 1);
    step("n_to10", 0, 0, 0);
    step("n_to10b", 1, 0, 0);

    // Asynchronous reset in mid-cycle with credit held at 10
    #3;
    reset = 1'b1;
    #1;
    m_credit = 0; m_y = 0; m_change = 0; m_err = 0;
    chk_all("async_rst");
    #2;
    reset = 1'b0;
    step("post_rst_n", 1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) mask = 3'($urandom_range(0, 7));
      else case ($urandom_range(0, 3))
        0:       mask = 3'b000;
        1:       mask = 3'b100;
        2:       mask = 3'b010;
        default: mask = 3'b001;
      endcase
      step("rand", mask[2], mask[1], mask[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
